// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the counter family.
//   MODE_SAT / MODE_WRAP : values for a counter's WRAP parameter.
//   clamp(value, lo, hi) : limits value to the inclusive range [lo, hi].
package counter_pkg;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

  // 32-bit so any counter width up to 32 can share it; callers cast the
  // result back to their own width.
  function automatic logic [31:0] clamp(input logic [31:0] value,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    logic [31:0] res;
    res = value;
    if (value < lo) res = lo;
    else if (value > hi) res = hi;
    return res;
  endfunction

endpackage

// File: rtl/updown_next_calc.sv
// updown_next_calc: combinational next-count for one enabled step.
//   count     : current count (assumed within [MIN_VAL, MAX_VAL])
//   step      : increment/decrement amount
//   up_down   : 1 = up, 0 = down
//   next_val  : count after the step, saturated or wrapped at the bounds
//   limit_hit : the step would have crossed a bound
module updown_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 7,
  parameter int WRAP    = MODE_SAT
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_val,
  output logic             limit_hit
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);

  // One extra bit so neither count+step nor MIN_VAL+step can overflow.
  logic [WIDTH:0] count_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum;

  assign count_x = {1'b0, count};
  assign step_x  = {1'b0, step};

  always_comb begin
    next_val  = count;
    limit_hit = 1'b0;
    sum       = count_x + step_x;
    if (up_down) begin
      if (sum <= MAX_X) begin
        next_val = sum[WIDTH-1:0];
      end else begin
        next_val  = (WRAP == MODE_WRAP) ? MIN_W : MAX_W;
        limit_hit = 1'b1;
      end
    end else begin
      // Compare against MIN+step rather than computing count-step, so no
      // borrow below zero is ever formed.
      if (count_x >= MIN_X + step_x) begin
        next_val = count - step;
      end else begin
        next_val  = (WRAP == MODE_WRAP) ? MAX_W : MIN_W;
        limit_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with bounds,
// saturate/wrap mode, variable step, clear, load and enable.
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   clr             : synchronous clear to MIN_VAL (highest priority)
//   load, load_val  : synchronous load, value clamped into range
//   en, up_down     : count enable and direction (1 = up)
//   step            : amount per enabled cycle
//   count           : the state register itself
//   at_max, at_min  : registered terminal flags, consistent with count
//   ovf, unf        : registered one-cycle pulses when a step hits a bound
// Priority each edge: rst > clr > load > en > hold.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 7,
  parameter int WRAP    = MODE_SAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] calc_next;
  logic             calc_hit;
  logic [WIDTH-1:0] count_d;
  logic             ovf_d;
  logic             unf_d;

  updown_next_calc #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .WRAP    (WRAP)
  ) u_next_calc (
    .count     (count),
    .step      (step),
    .up_down   (up_down),
    .next_val  (calc_next),
    .limit_hit (calc_hit)
  );

  always_comb begin
    count_d = count;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (clr) begin
      count_d = MIN_W;
    end else if (load) begin
      // Out-of-range loads are clamped silently; no event is raised.
      count_d = WIDTH'(clamp(32'(load_val), 32'(MIN_VAL), 32'(MAX_VAL)));
    end else if (en) begin
      count_d = calc_next;
      ovf_d   = calc_hit & up_down;
      unf_d   = calc_hit & ~up_down;
    end
  end

  // Flags are derived from count_d so they land on the same edge as count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= MIN_W;
      at_max <= 1'b0;
      at_min <= 1'b1;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      count  <= count_d;
      at_max <= (count_d == MAX_W);
      at_min <= (count_d == MIN_W);
      ovf    <= ovf_d;
      unf    <= unf_d;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: one default instance (3 bits, 0..7,
// saturate) and one wrapping instance (4 bits, 2..12). Both are tracked by
// an integer model; directed scenarios add literal expectations, then a
// randomized phase runs with occasional asynchronous resets.
module tb_updown_counter_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults ----------------
  logic       a_clr, a_load, a_en, a_ud;
  logic [2:0] a_lv, a_step, a_count;
  logic       a_at_max, a_at_min, a_ovf, a_unf;

  updown_counter_param dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .en(a_en), .up_down(a_ud), .step(a_step), .count(a_count),
    .at_max(a_at_max), .at_min(a_at_min), .ovf(a_ovf), .unf(a_unf)
  );

  // ---------------- DUT B: 4 bits, 2..12, wrap ----------------
  logic       b_clr, b_load, b_en, b_ud;
  logic [3:0] b_lv, b_step, b_count;
  logic       b_at_max, b_at_min, b_ovf, b_unf;

  updown_counter_param #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .WRAP(1)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_lv),
    .en(b_en), .up_down(b_ud), .step(b_step), .count(b_count),
    .at_max(b_at_max), .at_min(b_at_min), .ovf(b_ovf), .unf(b_unf)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nxt_cnt(input int mn, input int mx, input int wrap,
                                 input logic clr, input logic load, input logic en,
                                 input logic ud, input int lv, input int st, input int cnt);
    if (clr) return mn;
    if (load) return (lv < mn) ? mn : ((lv > mx) ? mx : lv);
    if (!en) return cnt;
    if (ud) begin
      if (cnt + st > mx) return wrap ? mn : mx;
      return cnt + st;
    end
    if (cnt - st < mn) return wrap ? mx : mn;
    return cnt - st;
  endfunction

  // {ovf, unf}
  function automatic logic [1:0] nxt_evt(input int mn, input int mx,
                                         input logic clr, input logic load, input logic en,
                                         input logic ud, input int st, input int cnt);
    if (clr || load || !en) return 2'b00;
    if (ud) return (cnt + st > mx) ? 2'b10 : 2'b00;
    return (cnt - st < mn) ? 2'b01 : 2'b00;
  endfunction

  int   ma_cnt, mb_cnt;
  logic ma_ovf, ma_unf, mb_ovf, mb_unf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma_cnt <= 0;  {ma_ovf, ma_unf} <= 2'b00;
      mb_cnt <= 2;  {mb_ovf, mb_unf} <= 2'b00;
    end else begin
      ma_cnt <= nxt_cnt(0, 7, 0, a_clr, a_load, a_en, a_ud, int'(a_lv), int'(a_step), ma_cnt);
      {ma_ovf, ma_unf} <= nxt_evt(0, 7, a_clr, a_load, a_en, a_ud, int'(a_step), ma_cnt);
      mb_cnt <= nxt_cnt(2, 12, 1, b_clr, b_load, b_en, b_ud, int'(b_lv), int'(b_step), mb_cnt);
      {mb_ovf, mb_unf} <= nxt_evt(2, 12, b_clr, b_load, b_en, b_ud, int'(b_step), mb_cnt);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("a_count",  int'(a_count),  ma_cnt);
      chk("a_at_max", int'(a_at_max), int'(ma_cnt == 7));
      chk("a_at_min", int'(a_at_min), int'(ma_cnt == 0));
      chk("a_ovf",    int'(a_ovf),    int'(ma_ovf));
      chk("a_unf",    int'(a_unf),    int'(ma_unf));
      chk("b_count",  int'(b_count),  mb_cnt);
      chk("b_at_max", int'(b_at_max), int'(mb_cnt == 12));
      chk("b_at_min", int'(b_at_min), int'(mb_cnt == 2));
      chk("b_ovf",    int'(b_ovf),    int'(mb_ovf));
      chk("b_unf",    int'(b_unf),    int'(mb_unf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic clr, input logic load, input logic [2:0] lv,
                         input logic en, input logic ud, input logic [2:0] st);
    a_clr = clr; a_load = load; a_lv = lv; a_en = en; a_ud = ud; a_step = st;
  endtask

  task automatic drive_b(input logic clr, input logic load, input logic [3:0] lv,
                         input logic en, input logic ud, input logic [3:0] st);
    b_clr = clr; b_load = load; b_lv = lv; b_en = en; b_ud = ud; b_step = st;
  endtask

  task automatic chk_a(input string name, input int cnt, input int mx, input int mn,
                       input int o, input int u);
    chk({name, ".count"},  int'(a_count),  cnt);
    chk({name, ".at_max"}, int'(a_at_max), mx);
    chk({name, ".at_min"}, int'(a_at_min), mn);
    chk({name, ".ovf"},    int'(a_ovf),    o);
    chk({name, ".unf"},    int'(a_unf),    u);
  endtask

  task automatic chk_b(input string name, input int cnt, input int mx, input int mn,
                       input int o, input int u);
    chk({name, ".count"},  int'(b_count),  cnt);
    chk({name, ".at_max"}, int'(b_at_max), mx);
    chk({name, ".at_min"}, int'(b_at_min), mn);
    chk({name, ".ovf"},    int'(b_ovf),    o);
    chk({name, ".unf"},    int'(b_unf),    u);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive_a(0, 0, 3'd0, 0, 0, 3'd0);
    drive_b(0, 0, 4'd0, 0, 0, 4'd0);
    #1 rst = 1'b0;
    #1;
    chk_a("reset_a", 0, 0, 1, 0, 0);
    chk_b("reset_b", 2, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    cmp_on = 1'b1;
    rst    = 1'b1;

    // Saturating count up by 3 from 0.
    drive_a(0, 0, 3'd0, 1, 1, 3'd3);
    tick(); chk_a("up3_c1", 3, 0, 0, 0, 0);
    tick(); chk_a("up3_c2", 6, 0, 0, 0, 0);
    tick(); chk_a("up3_c3", 7, 1, 0, 1, 0);
    tick(); chk_a("up3_c4", 7, 1, 0, 1, 0);

    // Asynchronous reset mid-count at 5, seen before any clock edge.
    drive_a(0, 1, 3'd5, 0, 1, 3'd0);
    tick(); chk_a("load5", 5, 0, 0, 0, 0);
    drive_a(0, 0, 3'd0, 0, 1, 3'd0);
    #3 rst = 1'b0;
    #1;
    chk_a("async_rst_a", 0, 0, 1, 0, 0);
    chk_b("async_rst_b", 2, 0, 1, 0, 0);
    #1 rst = 1'b1;
    tick();

    // Wrapping instance: down by 4 from 5 wraps to 12, then 8.
    drive_b(0, 1, 4'd5, 0, 0, 4'd0);
    tick(); chk_b("b_load5", 5, 0, 0, 0, 0);
    drive_b(0, 0, 4'd0, 1, 0, 4'd4);
    tick(); chk_b("b_wrap_dn", 12, 1, 0, 0, 1);
    tick(); chk_b("b_dn_8", 8, 0, 0, 0, 0);

    // Load clamps above MAX; clear beats load.
    drive_b(0, 1, 4'd14, 0, 0, 4'd0);
    tick(); chk_b("b_load14", 12, 1, 0, 0, 0);
    drive_b(1, 1, 4'd14, 0, 0, 4'd0);
    tick(); chk_b("b_clr_win", 2, 0, 1, 0, 0);
    drive_b(0, 1, 4'd0, 0, 0, 4'd0);
    tick(); chk_b("b_load_lo", 2, 0, 1, 0, 0);

    // Hold cases: step 0 with en, then en low with step 5.
    drive_a(0, 1, 3'd4, 0, 0, 3'd0);
    tick();
    drive_a(0, 0, 3'd0, 1, 1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_a("hold_step0", 4, 0, 0, 0, 0);
    end
    drive_a(0, 0, 3'd0, 0, 0, 3'd5);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_a("hold_en0", 4, 0, 0, 0, 0);
    end

    // Alternating direction with step 1 from 0.
    drive_a(1, 0, 3'd0, 0, 0, 3'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_a(0, 0, 3'd0, 1, (i % 2 == 0), 3'd1);
      tick(); chk_a("alt_ud", (i % 2 == 0) ? 1 : 0, 0, (i % 2 == 0) ? 0 : 1, 0, 0);
    end

    // Saturated at MIN stepping down pulses unf every cycle.
    drive_a(0, 0, 3'd0, 1, 0, 3'd2);
    tick(); chk_a("sat_dn1", 0, 0, 1, 0, 1);
    tick(); chk_a("sat_dn2", 0, 0, 1, 0, 1);

    // Randomized phase, checked by the per-cycle compare.
    for (int i = 0; i < 600; i++) begin
      drive_a(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      drive_b(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 63) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1 cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound in case stimulus ever stalls.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout reached at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
